// File: rtl/regfile_1w1r.sv
// regfile_1w1r: parametrised one-write/one-read register file with clear sweep, write-first bypass and range checks.
// Latency: read data, valid and error are registered one cycle after ren; writes land at the clock edge.
// Backpressure: none; while busy, reads return rerr and writes are dropped; init_req is ignored mid-sweep.
// Optional feature macro: REGFILE_PARITY_EN stores an even-parity bit per entry and adds the perr_inj input.
module regfile_1w1r #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              busy,
    input  logic              wen,
`ifdef REGFILE_PARITY_EN
    input  logic              perr_inj,
`endif
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rerr
);

`ifdef REGFILE_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]  w_cnt_nxt;
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0]  r_rdata;
    logic               r_rvalid;
    logic               r_rerr;

    logic               w_idle_go;
    logic               w_waddr_ok;
    logic               w_raddr_ok;
    logic               w_wr_acc;
    logic               w_rd_ok;
    logic               w_bypass;
    logic [ADDR_W-1:0]  w_raddr_safe;
    logic [ENTRY_W-1:0] w_rd_entry;
    logic [ENTRY_W-1:0] w_wr_entry;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_rd_perr;

    logic               w_mem_we;
    logic [ADDR_W-1:0]  w_mem_wa;
    logic [ENTRY_W-1:0] w_mem_wd;

    // Normal traffic is only served in IDLE when no sweep is starting at this edge.
    assign w_idle_go    = (r_state == S_IDLE) && !init_req;
    assign w_waddr_ok   = {1'b0, waddr} < LP_DEPTH;
    assign w_raddr_ok   = {1'b0, raddr} < LP_DEPTH;
    assign w_wr_acc     = wen && w_waddr_ok && w_idle_go;
    assign w_rd_ok      = w_raddr_ok && w_idle_go;
    assign w_bypass     = w_wr_acc && (raddr == waddr);
    // Keep the array index in range even when the request itself is out of range.
    assign w_raddr_safe = w_raddr_ok ? raddr : '0;
    assign w_rd_entry   = r_mem[w_raddr_safe];
    assign w_rd_data    = w_bypass ? wdata : w_rd_entry[DATA_W-1:0];

`ifdef REGFILE_PARITY_EN
    // Stored parity bit is even parity of the data, optionally inverted to model a fault.
    assign w_wr_entry = {(^wdata) ^ perr_inj, wdata};
    // On a bypassed read the stored parity would differ from recomputed parity exactly when perr_inj is set.
    assign w_rd_perr  = w_bypass ? perr_inj : ((^w_rd_entry[DATA_W-1:0]) != w_rd_entry[DATA_W]);
`else
    assign w_wr_entry = wdata;
    assign w_rd_perr  = 1'b0;
`endif

    // State register: reset lands in CLEAR with the sweep counter at entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: sweep one entry per cycle, stop on the last entry without wrapping; init_req only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (init_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs of the FSM: busy flag and the single array write port (sweep has priority over traffic).
    always_comb begin
        busy     = (r_state == S_CLEAR);
        w_mem_we = 1'b0;
        w_mem_wa = r_cnt;
        w_mem_wd = '0;
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                w_mem_we = 1'b1;
            end else if (w_wr_acc) begin
                w_mem_we = 1'b1;
                w_mem_wa = waddr;
                w_mem_wd = w_wr_entry;
            end
        end
    end

    // Storage array: not reset, contents are zeroed by the sweep instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    // Registered read port: valid pulse per ren, zero data with rerr on rejected reads, data held when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
        end else if (ren) begin
            r_rvalid <= 1'b1;
            if (w_rd_ok) begin
                r_rdata <= w_rd_data;
                r_rerr  <= w_rd_perr;
            end else begin
                r_rdata <= '0;
                r_rerr  <= 1'b1;
            end
        end else begin
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign rerr   = r_rerr;

endmodule

// File: tb/tb_regfile_1w1r.sv
// Bench for regfile_1w1r: a DEPTH=8 and a DEPTH=6 instance share one input stream.
// Directed vectors, hand-written multi-cycle sequences and random traffic are checked each cycle
// against a countdown/array reference model; define REGFILE_PARITY_EN to include the parity sequence.
module tb_regfile_1w1r;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, init_req, wen, ren, perr_inj;
    logic [2:0]    waddr, raddr;
    logic [DW-1:0] wdata;
    logic [1:0]    o_busy, o_rvalid, o_rerr;
    logic [DW-1:0] o_rdata [2];

    regfile_1w1r #(.DATA_W(DW), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .init_req(init_req), .busy(o_busy[0]),
        .wen(wen),
`ifdef REGFILE_PARITY_EN
        .perr_inj(perr_inj),
`endif
        .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(o_rdata[0]), .rvalid(o_rvalid[0]), .rerr(o_rerr[0])
    );

    regfile_1w1r #(.DATA_W(DW), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .init_req(init_req), .busy(o_busy[1]),
        .wen(wen),
`ifdef REGFILE_PARITY_EN
        .perr_inj(perr_inj),
`endif
        .waddr(waddr), .wdata(wdata), .ren(ren), .raddr(raddr),
        .rdata(o_rdata[1]), .rvalid(o_rvalid[1]), .rerr(o_rerr[1])
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: per instance a data array, a bad-parity flag per entry,
    // a count of sweep cycles still to run, and the last read result.
    int dep [2] = '{8, 6};
    int m_data [2][8];
    bit m_pbad [2][8];
    int m_left [2];
    bit m_vld [2];
    bit m_err [2];
    int m_dat [2];
    bit m_live = 1'b0;

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            automatic bit rej;
            if (rst) begin
                m_left[k] = dep[k];
                m_vld[k]  = 1'b0;
                m_err[k]  = 1'b0;
                m_dat[k]  = 0;
                m_live    = 1'b1;
            end else begin
                rej = (m_left[k] > 0) || init_req;
                if (ren) begin
                    m_vld[k] = 1'b1;
                    if (int'(raddr) >= dep[k] || rej) begin
                        m_dat[k] = 0;
                        m_err[k] = 1'b1;
                    end else if (wen && waddr == raddr) begin
                        m_dat[k] = int'(wdata);
                        m_err[k] = perr_inj;
                    end else begin
                        m_dat[k] = m_data[k][raddr];
                        m_err[k] = m_pbad[k][raddr];
                    end
                end else begin
                    m_vld[k] = 1'b0;
                    m_err[k] = 1'b0;
                end
                if (!rej && wen && int'(waddr) < dep[k]) begin
                    m_data[k][waddr] = int'(wdata);
                    m_pbad[k][waddr] = perr_inj;
                end
                if (m_left[k] > 0) begin
                    m_data[k][dep[k] - m_left[k]] = 0;
                    m_pbad[k][dep[k] - m_left[k]] = 1'b0;
                    m_left[k]--;
                end else if (init_req) begin
                    m_left[k] = dep[k];
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_busy_d%0d", dep[k]),   o_busy[k],   int'(m_left[k] > 0));
                chk($sformatf("model_rvalid_d%0d", dep[k]), o_rvalid[k], m_vld[k]);
                chk($sformatf("model_rerr_d%0d", dep[k]),   o_rerr[k],   m_err[k]);
                chk($sformatf("model_rdata_d%0d", dep[k]),  o_rdata[k],  m_dat[k]);
            end
        end
    endtask

    task automatic idle_inputs();
        init_req = 1'b0; wen = 1'b0; ren = 1'b0; perr_inj = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;
    endtask

    // Counts busy cycles of each instance until both are idle, bounded by a cycle budget.
    task automatic count_busy(input string tag);
        int n [2];
        n = '{0, 0};
        for (int i = 0; i < 40 && o_busy != 2'b00; i++) begin
            n[0] += int'(o_busy[0]);
            n[1] += int'(o_busy[1]);
            cycle();
        end
        chk({tag, "_timeout"}, o_busy, 0);
        chk({tag, "_len_d8"}, n[0], 8);
        chk({tag, "_len_d6"}, n[1], 6);
    endtask

    typedef struct {
        bit wen; int waddr; int wdata;
        bit ren; int raddr;
        bit vld; int dat8; bit err8; int dat6; bit err6;
    } vec_t;
    vec_t tbl [20];

    initial begin
        int n [2];

        // Directed vectors after the power-on sweep; expectations for both depths.
        for (int i = 0; i < 8; i++) tbl[i] = '{0, 0, 0, 1, i, 1, 0, 0, 0, (i >= 6)};
        tbl[8]  = '{1, 3, 'hA5, 0, 0, 0, 'h00, 0, 'h00, 0};
        tbl[9]  = '{1, 7, 'h3C, 0, 0, 0, 'h00, 0, 'h00, 0};
        tbl[10] = '{0, 0, 0,    1, 3, 1, 'hA5, 0, 'hA5, 0};
        tbl[11] = '{0, 0, 0,    1, 7, 1, 'h3C, 0, 'h00, 1};
        tbl[12] = '{0, 0, 0,    0, 0, 0, 'h3C, 0, 'h00, 0};
        tbl[13] = '{1, 5, 'h11, 0, 0, 0, 'h3C, 0, 'h00, 0};
        tbl[14] = '{1, 5, 'h22, 1, 5, 1, 'h22, 0, 'h22, 0};
        tbl[15] = '{0, 0, 0,    1, 5, 1, 'h22, 0, 'h22, 0};
        tbl[16] = '{1, 6, 'hFF, 0, 0, 0, 'h22, 0, 'h22, 0};
        tbl[17] = '{0, 0, 0,    1, 6, 1, 'hFF, 0, 'h00, 1};
        tbl[18] = '{0, 0, 0,    1, 5, 1, 'h22, 0, 'h22, 0};
        tbl[19] = '{0, 0, 0,    1, 3, 1, 'hA5, 0, 'hA5, 0};

        // Reset for two cycles, then check reset outputs and the sweep length.
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("rst_rdata",  o_rdata[k],  0);
            chk("rst_rvalid", o_rvalid[k], 0);
            chk("rst_rerr",   o_rerr[k],   0);
            chk("rst_busy",   o_busy[k],   1);
        end
        rst = 1'b0;
        count_busy("reset_sweep");

        // Table-driven vectors: post-sweep reads, write/read, collision, range.
        for (int i = 0; i < 20; i++) begin
            wen = tbl[i].wen; waddr = 3'(tbl[i].waddr); wdata = DW'(tbl[i].wdata);
            ren = tbl[i].ren; raddr = 3'(tbl[i].raddr);
            cycle();
            chk($sformatf("vec%0d_rvalid", i),    o_rvalid[0], tbl[i].vld);
            chk($sformatf("vec%0d_rdata_d8", i),  o_rdata[0],  tbl[i].dat8);
            chk($sformatf("vec%0d_rerr_d8", i),   o_rerr[0],   tbl[i].err8);
            chk($sformatf("vec%0d_rvalid6", i),   o_rvalid[1], tbl[i].vld);
            chk($sformatf("vec%0d_rdata_d6", i),  o_rdata[1],  tbl[i].dat6);
            chk($sformatf("vec%0d_rerr_d6", i),   o_rerr[1],   tbl[i].err6);
        end
        idle_inputs();

        // Init mid-traffic: fill with 0x5A, pulse init_req with a read in the same cycle.
        for (int a = 0; a < 8; a++) begin
            wen = 1'b1; waddr = 3'(a); wdata = 8'h5A;
            cycle();
        end
        idle_inputs();
        init_req = 1'b1; ren = 1'b1; raddr = 3'd2;
        cycle();
        chk("init_cycle_rd_rvalid", o_rvalid[0], 1);
        chk("init_cycle_rd_rerr",   o_rerr[0],   1);
        chk("init_cycle_rd_rdata",  o_rdata[0],  0);
        // Sweep: write/read @2 during busy, then a second init_req that must not extend it.
        n = '{0, 0};
        for (int j = 0; j < 40 && o_busy != 2'b00; j++) begin
            n[0] += int'(o_busy[0]);
            n[1] += int'(o_busy[1]);
            idle_inputs();
            if (j == 0) begin
                wen = 1'b1; waddr = 3'd2; wdata = 8'h77; ren = 1'b1; raddr = 3'd2;
            end
            if (j == 2) init_req = 1'b1;
            cycle();
            if (j == 0) begin
                chk("busy_rd_rvalid", o_rvalid[0], 1);
                chk("busy_rd_rerr",   o_rerr[0],   1);
                chk("busy_rd_rdata",  o_rdata[0],  0);
            end
        end
        idle_inputs();
        chk("init_timeout", o_busy, 0);
        chk("init_len_d8", n[0], 8);
        chk("init_len_d6", n[1], 6);
        for (int a = 0; a < 8; a++) begin
            ren = 1'b1; raddr = 3'(a);
            cycle();
            chk($sformatf("cleared_rdata_a%0d", a), o_rdata[0], 0);
            chk($sformatf("cleared_rerr_a%0d", a),  o_rerr[0],  0);
        end
        idle_inputs();

        // Reset during a sweep and in the same cycle as a read: pending rvalid dropped, sweep restarts.
        wen = 1'b1; waddr = 3'd4; wdata = 8'h99;
        cycle();
        idle_inputs();
        init_req = 1'b1;
        cycle();
        idle_inputs();
        cycle(); cycle(); cycle();
        rst = 1'b1; ren = 1'b1; raddr = 3'd4;
        cycle();
        chk("rst_drops_rvalid", o_rvalid[0], 0);
        rst = 1'b0; ren = 1'b0;
        count_busy("restart_sweep");

`ifdef REGFILE_PARITY_EN
        // Parity: injected fault flags rerr but still returns the data; clean rewrite clears it.
        wen = 1'b1; waddr = 3'd1; wdata = 8'h07; perr_inj = 1'b1;
        cycle();
        idle_inputs();
        ren = 1'b1; raddr = 3'd1;
        cycle();
        chk("par_bad_rvalid", o_rvalid[0], 1);
        chk("par_bad_rdata",  o_rdata[0],  'h07);
        chk("par_bad_rerr",   o_rerr[0],   1);
        idle_inputs();
        wen = 1'b1; waddr = 3'd1; wdata = 8'h07;
        cycle();
        idle_inputs();
        ren = 1'b1; raddr = 3'd1;
        cycle();
        chk("par_ok_rdata", o_rdata[0], 'h07);
        chk("par_ok_rerr",  o_rerr[0],  0);
        idle_inputs();
`endif

        // Random traffic checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            init_req = ($urandom_range(0, 39) == 0);
            wen      = 1'($urandom_range(0, 1));
            ren      = 1'($urandom_range(0, 1));
            waddr    = 3'($urandom_range(0, 7));
            raddr    = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            wdata    = DW'($urandom);
`ifdef REGFILE_PARITY_EN
            perr_inj = ($urandom_range(0, 7) == 0);
`endif
            cycle();
        end
        idle_inputs();
        rst = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_1w1r.md
Name: regfile_1w1r

Overview:
- Parametrised one-write/one-read register-file memory.
- Successor to the fixed 8x8 single-address scratch memory.
- Adds:
  - independent read and write addresses
  - registered read with a valid flag
  - write-to-read bypass
  - range checking
  - a hardware clear sequencer, which replaces the clear-on-reset array assignment
- Used as local scratch storage behind register/control logic in the datapath.

Parameters:
- DATA_W, 8: width of each entry in bits, >=1.
- DEPTH, 8: number of entries, >=2, need not be a power of 2.
- ADDR_W, $clog2(DEPTH): address width (derived localparam, not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- init_req  input  1  pulse: start clear sweep (all entries to 0).
- busy  output  1  high while clear sweep is running.
- wen  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- ren  input  1  read request.
- raddr  input  ADDR_W  read address.
- rdata  output  DATA_W  read data, registered.
- rvalid  output  1  rdata valid, one-cycle pulse per accepted read.
- rerr  output  1  accompanies rvalid: read was out of range or rejected.

Behaviour:
- Reset (rst=1 at a clk edge):
  - outputs: rdata=0, rvalid=0, rerr=0
  - state=CLEAR, clear counter=0, busy=1
  - array contents are not reset directly; the sweep zeroes them.
- FSM states:
  - CLEAR: writes entry[cnt]=0 each cycle; cnt increments.
    - At cnt==DEPTH-1, the entry is written and the FSM moves to IDLE next cycle.
    - Sweep length is exactly DEPTH cycles after rst deasserts.
    - busy=1 throughout CLEAR, and busy=0 the first cycle in IDLE.
  - IDLE: normal operation. init_req=1 -> CLEAR, cnt=0, busy=1 next cycle.
  - init_req while already in CLEAR: ignored; the sweep is not restarted.
- Write, IDLE only:
  - wen=1 and waddr<DEPTH: entry[waddr]<=wdata at the edge.
  - waddr>=DEPTH: write dropped silently.
  - wen while busy: dropped.
- Read, latency 1:
  - ren=1 at edge N -> rvalid=1 for the cycle after edge N, with rdata=entry[raddr].
  - Without ren, rvalid=0 and rdata holds its last value.
- Read/write collision:
  - Condition: wen=1 and ren=1, raddr==waddr<DEPTH, same cycle.
  - rdata = the new wdata (write-first bypass).
- Read error cases (rdata=0, rerr=1, rvalid=1):
  - raddr>=DEPTH.
  - ren while busy (including the cycle init_req is sampled in IDLE, since the sweep starts that edge).
- Reset mid-sweep restarts the sweep from cnt=0. Reset mid-read drops the pending rvalid.
- Counter width: ADDR_W, with no wrap past DEPTH-1.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores DATA_W+1 bits; the extra bit is even parity of the data.
  - The clear sweep writes parity 0.
  - On read, recomputed parity != stored parity -> rerr=1 with rvalid=1; rdata still returns the stored data.
  - Adds input perr_inj (1 bit): when high during a write, the stored parity bit is inverted (for test).
- Not defined:
  - No parity storage and no perr_inj port.
  - rerr covers range and busy cases only.

Test Plan:
- Reset sweep (DEPTH=8):
  - Stimulus: rst high 2 cycles, then low.
  - Required: busy=1 for exactly 8 cycles after release.
  - Then ren to every address gives rdata=0, rerr=0.
- Write/read (DATA_W=8):
  - Stimulus: write 0xA5@3 and 0x3C@7, then read 3 and 7.
  - Required: rvalid one cycle after each ren, rdata 0xA5 then 0x3C, rerr=0.
- Collision:
  - Stimulus: entry 5 holds 0x11; same cycle wen/waddr=5/wdata=0x22 and ren/raddr=5.
  - Required: next cycle rdata=0x22.
  - A follow-up read of 5 also returns 0x22.
- Range (DEPTH=6, ADDR_W=3):
  - Stimulus: write 0xFF@6, then read 6 and read 5.
  - Required: read 6 gives rvalid=1, rerr=1, rdata=0.
  - Read 5 gives its prior value with rerr=0; no entry is corrupted.
- Init mid-traffic:
  - Stimulus: fill all entries with 0x5A; pulse init_req; issue wen@2 and ren@2 during busy.
  - Required:
    - read returns rerr=1, rdata=0
    - write is dropped
    - after busy falls, all entries read 0
    - second init_req mid-sweep does not extend busy beyond DEPTH cycles
- Parity (REGFILE_PARITY_EN):
  - Stimulus: write 0x07@1 with perr_inj=1, then read 1.
  - Required: rdata=0x07, rvalid=1, rerr=1.
  - Rewrite with perr_inj=0 -> rerr=0.
